// File: rtl/y86_pkg.sv
// y86_pkg: shared ALU op codes, width and condition-code reset values
package y86_pkg;
  localparam int WIDTH = 64;
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_e;
  localparam logic CC_ZF_RST = 1'b1;
  localparam logic CC_SF_RST = 1'b0;
  localparam logic CC_OF_RST = 1'b0;
endpackage

// File: rtl/y86_alu_if.sv
// y86_alu_if: operand/result and condition-code bundle between execute stage and ALU
interface y86_alu_if import y86_pkg::*; #(parameter int WIDTH = y86_pkg::WIDTH);
  logic [1:0] operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic cc_en;
  logic [WIDTH-1:0] out;
  logic flag;
  logic zf;
  logic sf;
  logic of;
  modport master (output operation, a, b, cc_en, input out, flag, zf, sf, of);
  modport slave (input operation, a, b, cc_en, output out, flag, zf, sf, of);
endinterface

// File: rtl/y86_addsub.sv
// y86_addsub: shared adder/subtractor with signed-overflow detection
module y86_addsub #(parameter int WIDTH = 64) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);
  logic [WIDTH-1:0] bx;
  assign bx  = b ^ {WIDTH{sub}};
  assign sum = a + bx + {{(WIDTH-1){1'b0}}, sub};
  // overflow when both addends share a sign the result does not
  assign ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/y86_alu.sv
// y86_alu: combinational add/sub/and/xor datapath plus the ZF/SF/OF condition-code register
module y86_alu import y86_pkg::*; #(parameter int WIDTH = y86_pkg::WIDTH) (
  input logic clk,
  input logic rst_n,
  y86_alu_if.slave bus
);
  logic [WIDTH-1:0] sum;
  logic ovf;
  y86_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a  (bus.a),
    .b  (bus.b),
    .sub(bus.operation == ALU_SUB),
    .sum(sum),
    .ovf(ovf)
  );
  assign bus.out  = bus.operation == ALU_AND ? bus.a & bus.b :
                    bus.operation == ALU_XOR ? bus.a ^ bus.b : sum;
  assign bus.flag = bus.operation[1] ? 1'b0 : ovf;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.zf <= CC_ZF_RST;
      bus.sf <= CC_SF_RST;
      bus.of <= CC_OF_RST;
    end else if (bus.cc_en) begin
      bus.zf <= bus.out == '0;
      bus.sf <= bus.out[WIDTH-1];
      bus.of <= bus.flag;
    end
  end
endmodule

// File: tb/tb_y86_alu.sv
// tb_y86_alu: directed and randomized checks of y86_alu against an arithmetic reference model
module tb_y86_alu;
  import y86_pkg::*;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic checking = 1'b0;
  logic m_zf, m_sf, m_of;
  y86_alu_if #(.WIDTH(64)) bus ();
  y86_alu #(.WIDTH(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [63:0] ref_out(logic [1:0] op, logic [63:0] x, logic [63:0] y);
    return op == 2'd0 ? x + y : op == 2'd1 ? x - y : op == 2'd2 ? x & y : x ^ y;
  endfunction
  // true signed result computed wide; overflow iff it does not fit in 64 bits
  function automatic logic ref_flag(logic [1:0] op, logic [63:0] x, logic [63:0] y);
    logic signed [65:0] r;
    if (op[1]) return 1'b0;
    r = op == 2'd0 ? $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y})
                   : $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y});
    return (r > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (r < -66'sh0_8000_0000_0000_0000);
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (!rst_n) begin
      m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    end else if (bus.cc_en) begin
      m_zf = ref_out(bus.operation, bus.a, bus.b) == 64'd0;
      m_sf = ref_out(bus.operation, bus.a, bus.b) >= MINN;
      m_of = ref_flag(bus.operation, bus.a, bus.b);
    end
  end
  always @(negedge clk) begin
    if (checking) begin
      chk("out", bus.out, ref_out(bus.operation, bus.a, bus.b));
      chk("flag", {63'd0, bus.flag}, {63'd0, ref_flag(bus.operation, bus.a, bus.b)});
      chk("zf", {63'd0, bus.zf}, {63'd0, m_zf});
      chk("sf", {63'd0, bus.sf}, {63'd0, m_sf});
      chk("of", {63'd0, bus.of}, {63'd0, m_of});
    end
  end
  task automatic set_in(input logic [1:0] op, input logic [63:0] x, input logic [63:0] y,
                        input logic en, input logic rn);
    @(posedge clk);
    #1;
    bus.operation = op; bus.a = x; bus.b = y; bus.cc_en = en; rst_n = rn;
    #1;
  endtask
  task automatic cc(input string name, input logic z, input logic s, input logic o);
    chk(name, {61'd0, bus.zf, bus.sf, bus.of}, {61'd0, z, s, o});
  endtask
  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return MAXP;
      2: return MINN;
      3: return ONES;
      4: return 64'($urandom_range(0, 16));
      default: return {$urandom, $urandom};
    endcase
  endfunction
  initial begin
    bus.operation = 2'd0; bus.a = '0; bus.b = '0; bus.cc_en = 1'b1;
    set_in(ALU_ADD, MAXP, 1, 1, 0);
    set_in(ALU_SUB, ONES, 7, 1, 0);
    checking = 1'b1;
    set_in(ALU_ADD, 0, 0, 0, 1);
    cc("reset_cc", 1, 0, 0);
    repeat (3) set_in(ALU_ADD, MAXP, 1, 0, 1);
    cc("hold_cc", 1, 0, 0);
    set_in(ALU_ADD, 5, 3, 1, 1);
    chk("add_5_3", bus.out, 64'd8);
    chk("add_5_3_flag", {63'd0, bus.flag}, 64'd0);
    set_in(ALU_ADD, MAXP, 1, 1, 1);
    cc("cc_add_5_3", 0, 0, 0);
    chk("add_max_1", bus.out, MINN);
    chk("add_max_1_flag", {63'd0, bus.flag}, 64'd1);
    set_in(ALU_SUB, 64'h20, 8, 1, 1);
    cc("cc_add_max_1", 0, 1, 1);
    chk("sub_20_8", bus.out, 64'h18);
    set_in(ALU_SUB, 64'h1234, 64'h1234, 1, 1);
    chk("sub_x_x", bus.out, 64'd0);
    set_in(ALU_SUB, MINN, 1, 1, 1);
    cc("cc_sub_x_x", 1, 0, 0);
    chk("sub_min_1", bus.out, MAXP);
    chk("sub_min_1_flag", {63'd0, bus.flag}, 64'd1);
    set_in(ALU_SUB, 3, 5, 1, 1);
    chk("sub_3_5", bus.out, 64'hFFFF_FFFF_FFFF_FFFE);
    set_in(ALU_AND, 64'hF0F0, 64'hFF00, 0, 1);
    cc("cc_sub_3_5", 0, 1, 0);
    chk("and", bus.out, 64'hF000);
    set_in(ALU_XOR, 64'hF0F0, 64'hFF00, 0, 1);
    chk("xor", bus.out, 64'h0FF0);
    set_in(ALU_XOR, ONES, ONES, 1, 1);
    chk("xor_ones", bus.out, 64'd0);
    set_in(ALU_ADD, MAXP, 1, 0, 1);
    cc("cc_xor_ones", 1, 0, 0);
    chk("gated_flag", {63'd0, bus.flag}, 64'd1);
    set_in(ALU_ADD, MAXP, 1, 1, 1);
    cc("cc_gated_hold", 1, 0, 0);
    set_in(ALU_ADD, 0, 0, 0, 1);
    cc("cc_gated_load", 0, 1, 1);
    set_in(ALU_ADD, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1, 0);
    chk("rst_prio_out", bus.out, MINN);
    set_in(ALU_ADD, 0, 0, 0, 1);
    cc("cc_rst_prio", 1, 0, 0);
    for (int i = 0; i < 400; i++)
      set_in(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)),
             $urandom_range(0, 19) != 0);
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/y86_alu.md
Name: y86_alu

Overview:
- 64-bit integer ALU for the Y86-64 sequential processor's execute stage.
- Computes add, sub, and, xor on two signed operands, combinationally.
- Produces a combinational overflow flag.
- Holds the architectural condition-code register (ZF/SF/OF), loaded on the clock when enabled.
- The execute stage uses `out` as valE, and the `zf`/`sf`/`of` registers for cmovXX/jXX condition evaluation.

Parameters:
- WIDTH, 64, operand/result width in bits; the design and tests use 64.

Ports:
- clk  input  1  rising-edge clock; only the condition-code register is clocked.
- rst_n  input  1  synchronous active-low reset.
- operation  input  2  00 add, 01 sub, 10 and, 11 xor.
- a  input  WIDTH  signed operand A (valB for OPq, the stack pointer for push/pop/call/ret).
- b  input  WIDTH  signed operand B (valA for OPq, constant 8 for stack ops).
- cc_en  input  1  load condition codes from the current result at the next rising clk edge (OPq only).
- out  output  WIDTH  signed result, combinational.
- flag  output  1  signed overflow of the current operation, combinational.
- zf  output  1  registered zero flag.
- sf  output  1  registered sign flag.
- of  output  1  registered overflow flag.

Behaviour:
- Datapath is purely combinational: `out` and `flag` settle within the same cycle as a/b/operation change, with no latency. They are unaffected by reset and by `cc_en`.
- add: out = (a + b) mod 2^WIDTH.
- sub: out = (a − b) mod 2^WIDTH. Operand order is fixed: A minus B.
- and: out = a & b, bitwise.
- xor: out = a ^ b, bitwise.
- Carry-out is discarded; there is no carry output.
- Overflow, add: flag = (a[MSB] == b[MSB]) && (out[MSB] != a[MSB]).
- Overflow, sub: flag = (a[MSB] != b[MSB]) && (out[MSB] != a[MSB]).
- Overflow, and/xor: flag = 0.
- Condition-code register, synchronous update at rising clk:
  - If rst_n = 0: zf ← 1, sf ← 0, of ← 0 (Y86 reset CC). Reset has priority over cc_en.
  - Else if cc_en = 1: zf ← (out == 0), sf ← out[MSB], of ← flag, all taken from this cycle's combinational result.
  - Else: hold.
- Reset deasserts synchronously; the first load can occur on the first edge with rst_n = 1 and cc_en = 1.
- Boundaries:
  - Most-negative minus 1 overflows.
  - Max-positive plus 1 overflows.
  - x − x gives zero with no overflow.
  - and/xor never set OF, even when SF is set.
- No X propagation from an undriven `operation`: all four codes are defined and there is no default-case latch.

Decomposition:
- Shared package y86_pkg:
  - ALU op constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_XOR=2'b11.
  - WIDTH default 64.
  - CC reset constants (ZF=1, SF=0, OF=0).
- One natural sub-module, y86_addsub: WIDTH-bit adder/subtractor that computes a + (b ^ {WIDTH{sub}}) + sub, returning sum and signed-overflow.
- The top level instantiates y86_addsub and selects out/flag from either the adder or the bitwise and/xor logic, then adds the CC register.

Test Plan:
- Reset: hold rst_n=0 for 2 clks with cc_en=1 and arbitrary inputs -> zf=1, sf=0, of=0. Then with rst_n=1, cc_en=0, the flags hold across 3 clks.
- Add: a=5, b=3, op=00 -> out=8, flag=0. With cc_en=1, the next edge gives zf=0, sf=0, of=0. Also a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> out=0x8000_0000_0000_0000, flag=1; after cc_en: sf=1, of=1, zf=0.
- Sub: a=0x20, b=8, op=01 -> out=0x18, flag=0. a=b=0x1234 -> out=0; after cc_en: zf=1. a=0x8000_0000_0000_0000, b=1 -> out=0x7FFF_FFFF_FFFF_FFFF, flag=1. a=3, b=5 -> out=0xFFFF_FFFF_FFFF_FFFE, sf=1, of=0.
- Logic: a=0xF0F0, b=0xFF00, op=10 -> out=0xF000, flag=0. op=11 -> out=0x0FF0, flag=0. a=b=0xFFFF_FFFF_FFFF_FFFF with op=11 -> out=0; after cc_en: zf=1, of=0.
- CC enable gating: apply an overflowing add with cc_en=0 -> flag=1 combinationally, but zf/sf/of unchanged at the edge. Assert cc_en one cycle later -> of=1 at the following edge.
- Reset priority: rst_n=0 and cc_en=1 on the same edge, with an add result of 0x8000_0000_0000_0000 -> zf=1, sf=0, of=0. Meanwhile `out` still shows 0x8000_0000_0000_0000 combinationally.
